// File: rtl/book_levels_if.sv
// book_levels_if: tick bus from the feed decoder into the order book.
//   tick_valid : qualifies the tick, one per cycle, no backpressure
//   tick_type  : 0=add, 1=reduce, 2=replace, 3=clear
//   tick_side  : 1=bid, 0=ask
//   tick_qty   : quantity operand (QW bits, unsigned)
//   tick_price : price operand (PW bits, unsigned ticks)
// Modports: master (feed decoder side), slave (book side).
interface book_levels_if #(
    parameter int PW = 32,
    parameter int QW = 32
);
    logic          tick_valid;
    logic [1:0]    tick_type;
    logic          tick_side;
    logic [QW-1:0] tick_qty;
    logic [PW-1:0] tick_price;

    modport master (
        output tick_valid,
        output tick_type,
        output tick_side,
        output tick_qty,
        output tick_price
    );

    modport slave (
        input tick_valid,
        input tick_type,
        input tick_side,
        input tick_qty,
        input tick_price
    );
endinterface

// File: rtl/book_levels.sv
// book_levels: DEPTH-level limit order book for one instrument.
// Stage 1 registers the incoming tick; stage 2 applies it to the selected
// side array, so every tick sees the result of the previous one.
// Ports:
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   tick               : tick bus (slave modport of book_levels_if)
//   bid_px / bid_sz    : bid levels, descending, level 0 in the LSBs
//   ask_px / ask_sz    : ask levels, ascending, level 0 in the LSBs
//   bid_px0 .. ask_sz0 : level-0 aliases
//   bid_cnt, ask_cnt   : occupied levels per side
//   bbo_chg            : one-cycle pulse when any level-0 field changed
//   crossed            : both sides non-empty and bid_px0 >= ask_px0
//   drop_cnt, miss_cnt : saturating error counters
module book_levels #(
    parameter int PW    = 32,
    parameter int QW    = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    book_levels_if.slave                 tick,
    output logic [DEPTH*PW-1:0]          bid_px,
    output logic [DEPTH*QW-1:0]          bid_sz,
    output logic [DEPTH*PW-1:0]          ask_px,
    output logic [DEPTH*QW-1:0]          ask_sz,
    output logic [PW-1:0]                bid_px0,
    output logic [QW-1:0]                bid_sz0,
    output logic [PW-1:0]                ask_px0,
    output logic [QW-1:0]                ask_sz0,
    output logic [$clog2(DEPTH+1)-1:0]   bid_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   ask_cnt,
    output logic                         bbo_chg,
    output logic                         crossed,
    output logic [CW-1:0]                drop_cnt,
    output logic [CW-1:0]                miss_cnt
);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_REDUCE  = 2'd1,
        OP_REPLACE = 2'd2,
        OP_CLEAR   = 2'd3
    } op_t;

    function automatic logic [QW-1:0] sat_add_qty(input logic [QW-1:0] a,
                                                  input logic [QW-1:0] b);
        logic [QW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[QW] ? {QW{1'b1}} : s[QW-1:0];
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // "a is a better price than b" for the given side
    function automatic logic better(input logic          is_bid,
                                    input logic [PW-1:0] a,
                                    input logic [PW-1:0] b);
        return is_bid ? (a > b) : (a < b);
    endfunction

    // Book state
    logic [PW-1:0]   bid_px_r [DEPTH];
    logic [QW-1:0]   bid_sz_r [DEPTH];
    logic [PW-1:0]   ask_px_r [DEPTH];
    logic [QW-1:0]   ask_sz_r [DEPTH];
    logic [CNTW-1:0] bid_cnt_r;
    logic [CNTW-1:0] ask_cnt_r;

    // ---- Stage 1: tick register ----
    logic          vld_p1;
    op_t           type_p1;
    logic          side_p1;
    logic [QW-1:0] qty_p1;
    logic [PW-1:0] price_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= tick.tick_valid;
        end
    end

    always_ff @(posedge clk) begin
        type_p1  <= op_t'(tick.tick_type);
        side_p1  <= tick.tick_side;
        qty_p1   <= tick.tick_qty;
        price_p1 <= tick.tick_price;
    end

    // ---- Stage 2: apply tick to the selected side ----
    logic [PW-1:0]   cur_px [DEPTH];
    logic [QW-1:0]   cur_sz [DEPTH];
    logic [CNTW-1:0] cur_cnt;
    logic            full;
    logic            match_any;
    logic [CNTW-1:0] match_idx;
    logic [QW-1:0]   match_sz;
    logic [CNTW-1:0] ins_idx;
    logic            is_add;
    logic            is_del;
    logic [PW-1:0]   upd_px [DEPTH];
    logic [QW-1:0]   upd_sz [DEPTH];
    logic [CNTW-1:0] upd_cnt;
    logic            drop_inc;
    logic            miss_inc;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            cur_px[j] = side_p1 ? bid_px_r[j] : ask_px_r[j];
            cur_sz[j] = side_p1 ? bid_sz_r[j] : ask_sz_r[j];
        end
        cur_cnt = side_p1 ? bid_cnt_r : ask_cnt_r;
        full    = (cur_cnt == FULL_CNT);

        // Lowest occupied level with an equal price (prices are unique per side)
        match_any = 1'b0;
        match_idx = '0;
        match_sz  = '0;
        for (int j = DEPTH-1; j >= 0; j--) begin
            if ((CNTW'(j) < cur_cnt) && (cur_px[j] == price_p1)) begin
                match_any = 1'b1;
                match_idx = CNTW'(j);
                match_sz  = cur_sz[j];
            end
        end

        // First level that is empty or worse than the tick price; DEPTH means
        // the side is full and the tick is not better than the worst level.
        ins_idx = FULL_CNT;
        for (int j = DEPTH-1; j >= 0; j--) begin
            if ((CNTW'(j) >= cur_cnt) || better(side_p1, price_p1, cur_px[j])) begin
                ins_idx = CNTW'(j);
            end
        end

        for (int j = 0; j < DEPTH; j++) begin
            upd_px[j] = cur_px[j];
            upd_sz[j] = cur_sz[j];
        end
        upd_cnt  = cur_cnt;
        drop_inc = 1'b0;
        miss_inc = 1'b0;
        is_add   = 1'b0;
        is_del   = 1'b0;

        if (vld_p1) begin
            case (type_p1)
                OP_ADD: begin
                    if (qty_p1 != '0) is_add = 1'b1;
                end
                OP_REDUCE: begin
                    if (qty_p1 != '0) begin
                        if (!match_any) begin
                            miss_inc = 1'b1;
                        end else if (qty_p1 >= match_sz) begin
                            is_del = 1'b1;
                        end else begin
                            for (int j = 0; j < DEPTH; j++)
                                if (CNTW'(j) == match_idx) upd_sz[j] = match_sz - qty_p1;
                        end
                    end
                end
                OP_REPLACE: begin
                    if (match_any) begin
                        if (qty_p1 == '0) begin
                            is_del = 1'b1;
                        end else begin
                            for (int j = 0; j < DEPTH; j++)
                                if (CNTW'(j) == match_idx) upd_sz[j] = qty_p1;
                        end
                    end else if (qty_p1 != '0) begin
                        is_add = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end
                default: begin
                    for (int j = 0; j < DEPTH; j++) begin
                        upd_px[j] = '0;
                        upd_sz[j] = '0;
                    end
                    upd_cnt = '0;
                end
            endcase
        end

        if (is_add) begin
            if (match_any) begin
                for (int j = 0; j < DEPTH; j++)
                    if (CNTW'(j) == match_idx) upd_sz[j] = sat_add_qty(match_sz, qty_p1);
            end else begin
                if (full) drop_inc = 1'b1;
                if (ins_idx != FULL_CNT) begin
                    // Worse levels slide down; a full side loses its old worst level
                    for (int j = 1; j < DEPTH; j++) begin
                        if (CNTW'(j) > ins_idx) begin
                            upd_px[j] = cur_px[j-1];
                            upd_sz[j] = cur_sz[j-1];
                        end
                    end
                    for (int j = 0; j < DEPTH; j++) begin
                        if (CNTW'(j) == ins_idx) begin
                            upd_px[j] = price_p1;
                            upd_sz[j] = qty_p1;
                        end
                    end
                    if (!full) upd_cnt = cur_cnt + 1'b1;
                end
            end
        end

        if (is_del) begin
            // Worse levels slide up; empty levels already hold zero, so the
            // tail fills with zeros
            for (int j = 0; j < DEPTH-1; j++) begin
                if (CNTW'(j) >= match_idx) begin
                    upd_px[j] = cur_px[j+1];
                    upd_sz[j] = cur_sz[j+1];
                end
            end
            upd_px[DEPTH-1] = '0;
            upd_sz[DEPTH-1] = '0;
            upd_cnt = cur_cnt - 1'b1;
        end
    end

    // Route the updated side back, the other side holds
    logic [PW-1:0]   nxt_bid_px [DEPTH];
    logic [QW-1:0]   nxt_bid_sz [DEPTH];
    logic [PW-1:0]   nxt_ask_px [DEPTH];
    logic [QW-1:0]   nxt_ask_sz [DEPTH];
    logic [CNTW-1:0] nxt_bid_cnt;
    logic [CNTW-1:0] nxt_ask_cnt;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            nxt_bid_px[j] = side_p1 ? upd_px[j] : bid_px_r[j];
            nxt_bid_sz[j] = side_p1 ? upd_sz[j] : bid_sz_r[j];
            nxt_ask_px[j] = side_p1 ? ask_px_r[j] : upd_px[j];
            nxt_ask_sz[j] = side_p1 ? ask_sz_r[j] : upd_sz[j];
        end
        nxt_bid_cnt = side_p1 ? upd_cnt : bid_cnt_r;
        nxt_ask_cnt = side_p1 ? ask_cnt_r : upd_cnt;
    end

    // ---- Stage 2 register: book state, flags, counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                bid_px_r[j] <= '0;
                bid_sz_r[j] <= '0;
                ask_px_r[j] <= '0;
                ask_sz_r[j] <= '0;
            end
            bid_cnt_r <= '0;
            ask_cnt_r <= '0;
            bbo_chg   <= 1'b0;
            crossed   <= 1'b0;
            drop_cnt  <= '0;
            miss_cnt  <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                bid_px_r[j] <= nxt_bid_px[j];
                bid_sz_r[j] <= nxt_bid_sz[j];
                ask_px_r[j] <= nxt_ask_px[j];
                ask_sz_r[j] <= nxt_ask_sz[j];
            end
            bid_cnt_r <= nxt_bid_cnt;
            ask_cnt_r <= nxt_ask_cnt;
            bbo_chg   <= (nxt_bid_px[0] != bid_px_r[0]) || (nxt_bid_sz[0] != bid_sz_r[0]) ||
                         (nxt_ask_px[0] != ask_px_r[0]) || (nxt_ask_sz[0] != ask_sz_r[0]);
            crossed   <= (nxt_bid_cnt != '0) && (nxt_ask_cnt != '0) &&
                         (nxt_bid_px[0] >= nxt_ask_px[0]);
            if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
            if (miss_inc) miss_cnt <= sat_inc(miss_cnt);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign bid_px[g*PW +: PW] = bid_px_r[g];
        assign bid_sz[g*QW +: QW] = bid_sz_r[g];
        assign ask_px[g*PW +: PW] = ask_px_r[g];
        assign ask_sz[g*QW +: QW] = ask_sz_r[g];
    end

    assign bid_px0 = bid_px_r[0];
    assign bid_sz0 = bid_sz_r[0];
    assign ask_px0 = ask_px_r[0];
    assign ask_sz0 = ask_sz_r[0];
    assign bid_cnt = bid_cnt_r;
    assign ask_cnt = ask_cnt_r;
endmodule
